// File: rtl/adder_la_sequencer.sv
// Host-side sequencer for the instrumented adder's logic-analyzer port: loads operands,
// times a settle/run/settle window, then captures the wrapper's sum and ring count.
module adder_la_sequencer #(
    parameter int SETTLE_CYC = 4,
    parameter int RUN_W      = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic             cmd_ext,
    input  logic [4:0]       cmd_stop_bit,
    input  logic [RUN_W-1:0] cmd_cycles,
    output logic [31:0]      la_ctrl,
    output logic [31:0]      la_a,
    output logic [31:0]      la_b,
    input  logic [31:0]      la_sum_in,
    input  logic [31:0]      la_count_in,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_sum,
    output logic [31:0]      rsp_count,
    output logic             rsp_err,
    output logic             rsp_sat,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE, SETUP, ARM, RUN, DRAIN, CAPTURE, DONE
    } state_t;

    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [RUN_W-1:0] RUN_ONE     = RUN_W'(1);

    state_t           state_reg;
    logic [7:0]       settle_reg;
    logic [RUN_W-1:0] run_cnt_reg;
    logic             run_reg;
    logic             ext_reg;
    logic [4:0]       stop_reg;
    logic             clear_reg;

    assign la_ctrl = {15'd0, clear_reg, 3'd0, stop_reg, 6'd0, ext_reg, run_reg};

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_reg   <= IDLE;
            settle_reg  <= '0;
            run_cnt_reg <= '0;
            run_reg     <= 1'b0;
            ext_reg     <= 1'b0;
            stop_reg    <= '0;
            clear_reg   <= 1'b0;
            la_a        <= '0;
            la_b        <= '0;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_sum     <= '0;
            rsp_count   <= '0;
            rsp_err     <= 1'b0;
            rsp_sat     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cmd_cycles == '0) begin
                            // Zero-length window is rejected without touching the LA buses
                            state_reg <= DONE;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_sum   <= '0;
                            rsp_count <= '0;
                            rsp_sat   <= 1'b0;
                        end else begin
                            state_reg   <= SETUP;
                            la_a        <= cmd_a;
                            la_b        <= cmd_b;
                            ext_reg     <= cmd_ext;
                            stop_reg    <= cmd_stop_bit;
                            clear_reg   <= 1'b1;
                            run_cnt_reg <= cmd_cycles;
                        end
                    end
                end
                SETUP: begin
                    clear_reg  <= 1'b0;
                    settle_reg <= SETTLE_LAST;
                    state_reg  <= ARM;
                end
                ARM: begin
                    if (settle_reg == '0) begin
                        run_reg   <= 1'b1;
                        state_reg <= RUN;
                    end else begin
                        settle_reg <= settle_reg - 8'd1;
                    end
                end
                RUN: begin
                    // Terminate on 1 rather than 0 so the full-scale count never wraps
                    if (run_cnt_reg == RUN_ONE) begin
                        run_reg    <= 1'b0;
                        settle_reg <= SETTLE_LAST;
                        state_reg  <= DRAIN;
                    end else begin
                        run_cnt_reg <= run_cnt_reg - RUN_ONE;
                    end
                end
                DRAIN: begin
                    if (settle_reg == '0) begin
                        state_reg <= CAPTURE;
                    end else begin
                        settle_reg <= settle_reg - 8'd1;
                    end
                end
                CAPTURE: begin
                    rsp_sum   <= la_sum_in;
                    rsp_count <= la_count_in;
                    rsp_sat   <= &la_count_in;
                    rsp_err   <= 1'b0;
                    rsp_valid <= 1'b1;
                    state_reg <= DONE;
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_la_sequencer.sv
// Self-checking bench for adder_la_sequencer: directed table, randomized commands,
// and an asynchronous reset in the middle of a run window.
module tb_adder_la_sequencer;

    localparam int SETTLE = 4;
    localparam int RUN_W  = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [31:0]      cmd_a;
    logic [31:0]      cmd_b;
    logic             cmd_ext;
    logic [4:0]       cmd_stop_bit;
    logic [RUN_W-1:0] cmd_cycles;
    logic [31:0]      la_ctrl;
    logic [31:0]      la_a;
    logic [31:0]      la_b;
    logic [31:0]      la_sum_in;
    logic [31:0]      la_count_in;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_sum;
    logic [31:0]      rsp_count;
    logic             rsp_err;
    logic             rsp_sat;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    // Model of what the LA buses should currently show
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic        exp_ext;
    logic [4:0]  exp_stop;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ext;
        logic [4:0]  stop;
        logic [15:0] cycles;
        logic [31:0] sum;
        logic [31:0] count;
        int          delay;
    } vec_t;

    vec_t tbl[5];

    adder_la_sequencer #(.SETTLE_CYC(SETTLE), .RUN_W(RUN_W)) dut (
        .wb_clk_i     (clk),
        .wb_rst_n     (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_ext      (cmd_ext),
        .cmd_stop_bit (cmd_stop_bit),
        .cmd_cycles   (cmd_cycles),
        .la_ctrl      (la_ctrl),
        .la_a         (la_a),
        .la_b         (la_b),
        .la_sum_in    (la_sum_in),
        .la_count_in  (la_count_in),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_sum      (rsp_sum),
        .rsp_count    (rsp_count),
        .rsp_err      (rsp_err),
        .rsp_sat      (rsp_sat),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one command and follow it edge by edge; abort_at > 0 returns on that run cycle.
    task automatic do_cmd(input vec_t v, input int abort_at, output bit aborted);
        int n;
        int budget;
        int run_first;
        int run_last;
        int run_cnt;
        int clr_cnt;
        int clr_k;
        int valid_k;
        int la_bad;
        int hold_bad;
        logic [31:0] want_sum;
        logic [31:0] want_count;
        n         = int'(v.cycles);
        aborted   = 1'b0;
        run_first = -1;
        run_last  = -1;
        run_cnt   = 0;
        clr_cnt   = 0;
        clr_k     = -1;
        valid_k   = -1;
        la_bad    = 0;
        hold_bad  = 0;
        budget    = n + 2 * SETTLE + 20;

        @(negedge clk);
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_a        = v.a;
        cmd_b        = v.b;
        cmd_ext      = v.ext;
        cmd_stop_bit = v.stop;
        cmd_cycles   = v.cycles;
        cmd_valid    = 1'b1;
        la_sum_in    = v.sum;
        la_count_in  = v.count;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (n != 0) begin
            exp_a    = v.a;
            exp_b    = v.b;
            exp_ext  = v.ext;
            exp_stop = v.stop;
        end

        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (la_ctrl[0]) begin
                if (run_first < 0) run_first = k;
                run_last = k;
                run_cnt++;
            end
            if (la_ctrl[16]) begin
                clr_cnt++;
                clr_k = k;
            end
            if (la_a !== exp_a || la_b !== exp_b || la_ctrl[1] !== exp_ext ||
                la_ctrl[12:8] !== exp_stop || (la_ctrl & 32'hFFFE_E0FC) !== 32'd0 ||
                cmd_ready !== 1'b0 || busy !== 1'b1)
                la_bad++;
            if (abort_at > 0 && run_cnt == abort_at) begin
                aborted = 1'b1;
                break;
            end
            if (rsp_valid) begin
                valid_k = k;
                break;
            end
            // Garbage on the command port while busy must be ignored
            cmd_a      = $urandom;
            cmd_b      = $urandom;
            cmd_cycles = RUN_W'($urandom);
            cmd_valid  = 1'b1;
        end
        cmd_valid = 1'b0;
        chk("la_bus_stable", la_bad, 0);
        if (aborted) return;

        chk("valid_latency", valid_k, (n == 0) ? 1 : 3 + 2 * SETTLE + n);
        chk("run_cycles", run_cnt, n);
        chk("clear_cycles", clr_cnt, (n == 0) ? 0 : 1);
        if (n != 0) begin
            chk("run_first_edge", run_first, 2 + SETTLE);
            chk("run_last_edge", run_last, 1 + SETTLE + n);
            chk("clear_edge", clr_k, 1);
        end
        want_sum   = (n == 0) ? 32'd0 : v.sum;
        want_count = (n == 0) ? 32'd0 : v.count;
        chk("rsp_sum", rsp_sum, want_sum);
        chk("rsp_count", rsp_count, want_count);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, n == 0});
        chk("rsp_sat", {31'd0, rsp_sat}, {31'd0, n != 0 && v.count == 32'hFFFF_FFFF});

        for (int i = 0; i < v.delay; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_sum !== want_sum || rsp_count !== want_count ||
                cmd_ready !== 1'b0)
                hold_bad++;
        end
        chk("rsp_hold", hold_bad, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_taken", {31'd0, rsp_valid}, 32'd0);
        chk("ready_after", {30'd0, cmd_ready, busy}, 32'd2);
        chk("rsp_sum_held", rsp_sum, want_sum);
        $display("cmd a=%08h b=%08h cycles=%0d -> sum=%08h count=%08h err=%0b sat=%0b",
                 v.a, v.b, n, rsp_sum, rsp_count, rsp_err, rsp_sat);
    endtask

    initial begin
        bit   ab;
        vec_t v;

        tbl[0] = '{a: 32'd5, b: 32'd7, ext: 1'b0, stop: 5'd3, cycles: 16'd10,
                   sum: 32'd12, count: 32'h1234, delay: 0};
        tbl[1] = '{a: 32'd5, b: 32'd7, ext: 1'b0, stop: 5'd3, cycles: 16'd10,
                   sum: 32'd12, count: 32'h1234, delay: 7};
        tbl[2] = '{a: 32'hDEAD_BEEF, b: 32'h0BAD_F00D, ext: 1'b1, stop: 5'd17, cycles: 16'd0,
                   sum: 32'h5555_5555, count: 32'h7777, delay: 2};
        tbl[3] = '{a: 32'h8000_0000, b: 32'h8000_0000, ext: 1'b1, stop: 5'd31, cycles: 16'd1,
                   sum: 32'd0, count: 32'hFFFF_FFFF, delay: 1};
        tbl[4] = '{a: 32'h0000_FFFF, b: 32'h0000_0001, ext: 1'b0, stop: 5'd8, cycles: 16'hFFFF,
                   sum: 32'h0001_0000, count: 32'hABCD_0123, delay: 0};

        rst_n        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_a        = '0;
        cmd_b        = '0;
        cmd_ext      = 1'b0;
        cmd_stop_bit = '0;
        cmd_cycles   = '0;
        la_sum_in    = '0;
        la_count_in  = '0;
        rsp_ready    = 1'b0;
        exp_a        = '0;
        exp_b        = '0;
        exp_ext      = 1'b0;
        exp_stop     = '0;

        repeat (3) @(negedge clk);
        chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("reset_la_ctrl", la_ctrl, 32'd0);
        chk("reset_la_ab", la_a | la_b, 32'd0);
        chk("reset_rsp", {28'd0, rsp_valid, rsp_err, rsp_sat, busy}, 32'd0);
        chk("reset_rsp_data", rsp_sum | rsp_count, 32'd0);
        rst_n = 1'b1;

        for (int t = 0; t < 5; t++) do_cmd(tbl[t], 0, ab);

        for (int r = 0; r < 10; r++) begin
            v.a      = $urandom;
            v.b      = $urandom;
            v.ext    = 1'($urandom);
            v.stop   = 5'($urandom);
            v.cycles = 16'($urandom_range(0, 30));
            v.sum    = v.a + v.b;
            v.count  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            v.delay  = $urandom_range(0, 4);
            do_cmd(v, 0, ab);
        end

        // Asynchronous reset on the 5th run cycle, away from any clock edge
        v = '{a: 32'h1111_2222, b: 32'h3333_4444, ext: 1'b1, stop: 5'd12, cycles: 16'd20,
              sum: 32'h4444_6666, count: 32'h99, delay: 0};
        do_cmd(v, 5, ab);
        chk("abort_reached", {31'd0, ab}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_la_ctrl", la_ctrl, 32'd0);
        chk("async_rst_state", {29'd0, rsp_valid, cmd_ready, busy}, 32'd2);
        chk("async_rst_la_a", la_a, 32'd0);
        exp_a    = '0;
        exp_b    = '0;
        exp_ext  = 1'b0;
        exp_stop = '0;
        #1 rst_n = 1'b1;
        do_cmd(v, 0, ab);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
